// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter.
// Holds the transmit FSM state type, the 8N1 frame constants and the
// default bit period used by uart_tx.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam logic START_BIT       = 1'b0;
  localparam logic STOP_BIT        = 1'b1;
  localparam int   DATA_BITS       = 8;
  localparam int   DIVIDER_DEFAULT = 16;

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream handshake into the UART transmitter.
//   iData  : byte offered by the producer
//   iValid : iData is valid this cycle
//   oReady : transmitter can take a byte this cycle
// A byte moves on any rising edge where iValid && oReady.
interface uart_tx_if;

  logic [7:0] iData;
  logic       iValid;
  logic       oReady;

  modport master (output iData, output iValid, input  oReady);
  modport slave  (input  iData, input  iValid, output oReady);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO buffering transmit data ahead of the serialiser.
//   clk, reset          : clock, synchronous active-high reset
//   push_i, wdata_i     : write request and byte (ignored when full)
//   pop_i, rdata_o      : read request and head byte (ignored when empty)
//   full_o, empty_o     : occupancy flags from registered count
//   count_o             : current number of stored bytes (0..DEPTH)
module uart_tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push_i,
  input  logic [7:0]                   wdata_i,
  input  logic                         pop_i,
  output logic [7:0]                   rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [7:0]       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Full blocks the push even when a pop frees a slot in the same cycle,
  // so acceptance never depends on the consumer's combinational decision.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage carries data only and needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO.
//   clk, reset : clock, synchronous active-high reset
//   bus        : byte handshake (iData, iValid in; oReady out)
//   TX         : registered serial line, idles high
//   oBusy      : a frame is on the line or bytes are still queued
// Each bit is held for DIVIDER clocks; frames queued in the FIFO follow
// each other with no idle gap between stop and start bits.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DIVIDER = DIVIDER_DEFAULT,
  parameter int DEPTH   = 4
) (
  input  logic      clk,
  input  logic      reset,
  uart_tx_if.slave  bus,
  output logic      TX,
  output logic      oBusy
);

  localparam int               CNT_W    = $clog2(DIVIDER);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);

  uart_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  logic             pop;
  logic [7:0]       head;
  logic             full;
  logic             empty;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic             bit_done;

  uart_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (bus.iValid),
    .wdata_i (bus.iData),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  // Ready depends only on the registered count; it is held low while
  // reset is asserted so nothing is offered during the reset cycle.
  assign bus.oReady = !full && !reset;
  assign TX         = tx_q;
  assign oBusy      = (state_q != IDLE) || (count != '0);

  assign bit_done = (cnt_q == CNT_LAST);

  // tx_d is the value the line takes after the next edge, so every
  // transition loads the first value of the bit being entered.
  always_comb begin
    state_d = state_q;
    cnt_d   = bit_done ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = STOP_BIT;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = head;
          state_d = START;
          tx_d    = START_BIT;
        end
      end
      START: begin
        if (bit_done) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = STOP;
            tx_d    = STOP_BIT;
          end else begin
            shift_d = shift_q >> 1;
            idx_d   = idx_q + 3'd1;
            tx_d    = shift_q[1];
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = START;
            tx_d    = START_BIT;
          end else begin
            state_d = IDLE;
            tx_d    = STOP_BIT;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx (DIVIDER=16, DEPTH=4).
// A line decoder collects every complete frame seen on TX together with
// its start cycle and whether all ten bit windows were 16 cycles wide with
// correct start/stop levels; the scenario tasks compare against that.
module tb_uart_tx;

  localparam int DIV   = 16;
  localparam int DEP   = 4;
  localparam int FRAME = 10 * DIV;

  logic clk = 1'b0;
  logic reset;
  logic TX;
  logic oBusy;

  uart_tx_if bus ();

  uart_tx #(.DIVIDER(DIV), .DEPTH(DEP)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .TX    (TX),
    .oBusy (oBusy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] data;
    int         start;
    bit         ok;
  } frame_t;

  frame_t frames[$];

  // Line decoder, sampling at negedge.
  bit         mon_in = 1'b0;
  int         mon_k = 0;
  int         mon_st = 0;
  logic       mon_prev = 1'b1;
  logic       mon_win;
  bit         mon_uni;
  logic [9:0] mon_bits;
  frame_t     mon_fr;

  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        mon_in = 1'b0;
      end else begin
        if (!mon_in && mon_prev === 1'b1 && TX === 1'b0) begin
          mon_in  = 1'b1;
          mon_k   = 0;
          mon_st  = cyc;
          mon_uni = 1'b1;
        end
        if (mon_in) begin
          if (mon_k % DIV == 0) begin
            mon_win = TX;
            mon_bits[mon_k / DIV] = TX;
          end else if (TX !== mon_win) begin
            mon_uni = 1'b0;
          end
          mon_k++;
          if (mon_k == FRAME) begin
            mon_fr.data  = mon_bits[8:1];
            mon_fr.start = mon_st;
            mon_fr.ok    = mon_uni && (mon_bits[0] === 1'b0) && (mon_bits[9] === 1'b1);
            frames.push_back(mon_fr);
            mon_in = 1'b0;
          end
        end
      end
      mon_prev = TX;
    end
  end

  task automatic wait_frames(input int n, input int budget);
    int t = 0;
    while (frames.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (oBusy !== 1'b0 && t < budget) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.iValid = 1'b0;
    bus.iData = 8'h00;
    repeat (2) @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b, expected 1", TX); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, expected 0", oBusy); end
    checks++; if (bus.oReady !== 1'b0) begin errors++; $display("FAIL reset_ready_during: got %b, expected 0", bus.oReady); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.oReady !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b, expected 1", bus.oReady); end
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL reset_tx_after: got %b, expected 1", TX); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL reset_busy_after: got %b, expected 0", oBusy); end
  endtask

  task automatic test_single();
    int acc;
    frames.delete();
    bus.iValid = 1'b1;
    bus.iData  = 8'h55;
    @(negedge clk);
    bus.iValid = 1'b0;
    acc = cyc;
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL single_tx_before_fall: got %b, expected 1", TX); end
    checks++; if (oBusy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, expected 1", oBusy); end
    @(negedge clk);
    checks++; if (TX !== 1'b0) begin errors++; $display("FAIL single_fall_latency: got %b, expected 0", TX); end
    wait_idle(400);
    checks++; if (cyc != acc + 161) begin errors++; $display("FAIL single_busy_end: got cycle %0d, expected %0d", cyc, acc + 161); end
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL single_tx_idle: got %b, expected 1", TX); end
    checks++;
    if (frames.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d frames, expected 1", frames.size());
    end else if (frames[0].data !== 8'h55 || !frames[0].ok || frames[0].start != acc + 1) begin
      errors++; $display("FAIL single_frame: got data %h ok %0d start %0d, expected 55 1 %0d",
                         frames[0].data, frames[0].ok, frames[0].start, acc + 1);
    end
  endtask

  task automatic test_back_to_back();
    int acc;
    frames.delete();
    bus.iValid = 1'b1;
    bus.iData  = 8'hA5;
    @(negedge clk);
    acc = cyc;
    bus.iData = 8'h3C;
    @(negedge clk);
    bus.iValid = 1'b0;
    wait_frames(2, 400);
    checks++;
    if (frames.size() != 2) begin
      errors++; $display("FAIL b2b_count: got %0d frames, expected 2", frames.size());
    end else begin
      if (frames[0].data !== 8'hA5 || !frames[0].ok || frames[0].start != acc + 1) begin
        errors++; $display("FAIL b2b_first: got data %h ok %0d start %0d, expected a5 1 %0d",
                           frames[0].data, frames[0].ok, frames[0].start, acc + 1);
      end
      checks++;
      if (frames[1].data !== 8'h3C || !frames[1].ok || frames[1].start != acc + 161) begin
        errors++; $display("FAIL b2b_second: got data %h ok %0d start %0d, expected 3c 1 %0d",
                           frames[1].data, frames[1].ok, frames[1].start, acc + 161);
      end
    end
    wait_idle(400);
    checks++; if (cyc != acc + 321) begin errors++; $display("FAIL b2b_total: got cycle %0d, expected %0d", cyc, acc + 321); end
  endtask

  task automatic test_zero_ff();
    frames.delete();
    bus.iValid = 1'b1;
    bus.iData  = 8'h00;
    @(negedge clk);
    bus.iData = 8'hFF;
    @(negedge clk);
    bus.iValid = 1'b0;
    wait_frames(2, 400);
    checks++;
    if (frames.size() != 2) begin
      errors++; $display("FAIL zero_ff_count: got %0d frames, expected 2", frames.size());
    end else if (frames[0].data !== 8'h00 || !frames[0].ok || frames[1].data !== 8'hFF || !frames[1].ok
                 || frames[1].start - frames[0].start != FRAME) begin
      errors++; $display("FAIL zero_ff_frames: got %h/%0d %h/%0d spacing %0d, expected 00/1 ff/1 spacing %0d",
                         frames[0].data, frames[0].ok, frames[1].data, frames[1].ok,
                         frames[1].start - frames[0].start, FRAME);
    end
    wait_idle(400);
  endtask

  task automatic test_full();
    logic [7:0] vals [6];
    int  acc [6];
    int  i = 0;
    int  t = 0;
    bit  rdy;
    bit  ee_taken = 1'b0;
    for (int j = 0; j < 6; j++) vals[j] = 8'(j + 1);
    frames.delete();
    bus.iValid = 1'b1;
    bus.iData  = vals[0];
    while (i < 5 && t < 50) begin
      rdy = bus.oReady;
      @(negedge clk);
      t++;
      if (rdy) begin
        acc[i] = cyc;
        i++;
        bus.iData = vals[i];
      end
    end
    checks++; if (i != 5 || acc[4] != acc[0] + 4) begin errors++; $display("FAIL full_fill: got %0d accepted in %0d cycles, expected 5 in 4", i, acc[4] - acc[0]); end
    checks++; if (bus.oReady !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, expected 0", bus.oReady); end
    bus.iData = 8'hEE;
    repeat (20) begin
      rdy = bus.oReady;
      @(negedge clk);
      if (rdy) ee_taken = 1'b1;
    end
    checks++; if (ee_taken) begin errors++; $display("FAIL full_push_ignored: got accepted 1, expected 0"); end
    bus.iData = vals[5];
    t = 0;
    while (i < 6 && t < 300) begin
      rdy = bus.oReady;
      @(negedge clk);
      t++;
      if (rdy) begin
        acc[5] = cyc;
        i++;
      end
    end
    bus.iValid = 1'b0;
    checks++;
    if (i != 6 || acc[5] != acc[0] + 162) begin
      errors++; $display("FAIL full_sixth_accept: got accepted %0d at offset %0d, expected 6 at offset 162", i, acc[5] - acc[0]);
    end
    wait_frames(6, 1200);
    checks++;
    if (frames.size() != 6) begin
      errors++; $display("FAIL full_count: got %0d frames, expected 6", frames.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        checks++;
        if (frames[j].data !== vals[j] || !frames[j].ok || frames[j].start != acc[0] + 1 + FRAME * j) begin
          errors++; $display("FAIL full_frame%0d: got data %h ok %0d start %0d, expected %h 1 %0d",
                             j, frames[j].data, frames[j].ok, frames[j].start, vals[j], acc[0] + 1 + FRAME * j);
        end
      end
    end
    wait_idle(400);
  endtask

  task automatic test_reset_midframe();
    int acc;
    bit line_low = 1'b0;
    frames.delete();
    bus.iValid = 1'b1;
    bus.iData  = 8'h11;
    @(negedge clk);
    acc = cyc;
    bus.iData = 8'h22;
    @(negedge clk);
    bus.iData = 8'h33;
    @(negedge clk);
    bus.iValid = 1'b0;
    while (cyc < acc + 51) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++; if (TX !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b, expected 1", TX); end
    checks++; if (oBusy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b, expected 0", oBusy); end
    checks++; if (bus.oReady !== 1'b0) begin errors++; $display("FAIL midreset_ready: got %b, expected 0", bus.oReady); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.oReady !== 1'b1 || oBusy !== 1'b0) begin errors++; $display("FAIL midreset_after: got ready %b busy %b, expected 1 0", bus.oReady, oBusy); end
    repeat (400) begin
      @(negedge clk);
      if (TX !== 1'b1) line_low = 1'b1;
    end
    checks++; if (line_low || frames.size() != 0) begin errors++; $display("FAIL midreset_no_resume: got line_low %0d frames %0d, expected 0 0", line_low, frames.size()); end
    bus.iValid = 1'b1;
    bus.iData  = 8'h81;
    @(negedge clk);
    bus.iValid = 1'b0;
    acc = cyc;
    wait_frames(1, 300);
    checks++;
    if (frames.size() != 1) begin
      errors++; $display("FAIL midreset_new_count: got %0d frames, expected 1", frames.size());
    end else if (frames[0].data !== 8'h81 || !frames[0].ok || frames[0].start != acc + 1) begin
      errors++; $display("FAIL midreset_new_frame: got data %h ok %0d start %0d, expected 81 1 %0d",
                         frames[0].data, frames[0].ok, frames[0].start, acc + 1);
    end
    wait_idle(400);
  endtask

  initial begin
    reset = 1'b1;
    bus.iValid = 1'b0;
    bus.iData = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_zero_ff();
    test_full();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter DIVIDER, default 16: clk cycles per UART bit; legal range 2..255.
REQ-002 SHALL have parameter DEPTH, default 4: transmit FIFO entries; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port iData, input, 8: byte to transmit.
REQ-006 SHALL have port iValid, input, 1: iData valid this cycle.
REQ-007 SHALL have port oReady, output, 1: FIFO can accept a byte this cycle.
REQ-008 SHALL have port TX, output, 1: serial line, registered, idle high.
REQ-009 SHALL have port oBusy, output, 1: a frame is on the line or the FIFO is non-empty.

Function
REQ-010 SHALL frame each byte as 8N1: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
REQ-011 SHALL hold every bit on TX for exactly DIVIDER clk cycles; one frame is 10*DIVIDER cycles.
REQ-012 SHALL accept a byte on any rising edge where iValid && oReady; iData is ignored when oReady is low.
REQ-013 SHALL drive oReady = (FIFO count < DEPTH) from registered state only; there is no combinational path from iValid.
REQ-014 SHALL not accept a push when the FIFO is full, even if a pop occurs in the same cycle.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: TX=1; if the FIFO is non-empty, pop the head, latch it into the shift register, go to START, and drive TX=0 from the next edge.
REQ-017 START: after DIVIDER cycles go to DATA with bit index 0.
REQ-018 DATA: output the shift register LSB; every DIVIDER cycles shift right and increment the bit index; after index 7 completes, go to STOP.
REQ-019 STOP: TX=1 for DIVIDER cycles; at its last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
REQ-020 Latency: a byte accepted at edge N into an empty FIFO with the FSM in IDLE SHALL produce the TX falling edge at edge N+1.
REQ-021 The bit counter SHALL be $clog2(DIVIDER) bits wide and SHALL wrap to 0 on terminal count DIVIDER-1.
REQ-022 FIFO pointers SHALL wrap modulo DEPTH; the count SHALL be DEPTH+1 values wide; a simultaneous push and pop when non-full and non-empty SHALL leave the count unchanged.
REQ-023 oBusy SHALL be high whenever state != IDLE or count != 0, and low in IDLE with an empty FIFO.

Reset
REQ-024 On reset: TX=1, oBusy=0, oReady=0 during the reset cycle then 1, state=IDLE, counters, pointers and count = 0, shift register = 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame: TX=1 from the next edge, FIFO contents discarded, and no partial frame resumes.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state typedef, the frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8) and DIVIDER default.
REQ-027 The FIFO SHALL be one sub-module uart_tx_fifo (parameter DEPTH, 8-bit width, push/pop/full/empty/count); the FSM and bit timer live in uart_tx.

Verification (DIVIDER=16, DEPTH=4)
REQ-028 Push 0x55 while idle -> TX falls 1 cycle later; bit sequence 0,1,0,1,0,1,0,1,0,1, each 16 cycles; TX high and oBusy=0 after 160 cycles.
REQ-029 Push 0xA5 then 0x3C on consecutive cycles -> two frames, 320 cycles total, stop bit of the first immediately followed by start bit of the second, data LSB first 1,0,1,0,0,1,0,1 then 0,0,1,1,1,1,0,0.
REQ-030 Hold iValid high with bytes 0x01..0x06 -> 5 accepted (1 popped plus 4 buffered), oReady low until the first stop bit ends, 0x06 accepted on the pop cycle+1, all 6 transmitted in order.
REQ-031 Push 0x00 and 0xFF -> 9 low bit-times then high; 1 low bit-time then 9 high bit-times.
REQ-032 Push 3 bytes, assert reset for 1 cycle at cycle 50 of frame 1 -> TX=1 from the next edge, oBusy=0, no further frames; a new push of 0x81 afterwards transmits correctly.
REQ-033 Push when full (iValid=1, oReady=0) with 0xEE -> byte is not transmitted; FIFO order is unchanged.
